// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  // R-type field view of a fetched word, as decode slices it
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_structure_t;

  localparam logic [31:0] NOP_WORD_C       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: imem request FSM, pc, redirect flush, delivery pulse
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        jFlag,
  input  logic [31:0] PC_in,
  output logic [31:0] instr,
  output logic [31:0] PC_out,
  output logic        done_out,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         flush_q, flush_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         done_q, done_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  count_q, count_d;

  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  assign target   = {PC_in[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    done_d     = 1'b0;
    misalign_d = misalign_q | (jFlag & (PC_in[1:0] != 2'b00));
    count_d    = count_q + {31'd0, done_q};

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        pc_d    = jFlag ? target : pc_q;
        addr_d  = jFlag ? target : pc_q;
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (flush_q || jFlag) begin
            // Wrong-path word: drop it and reissue at the (possibly new) target
            flush_d = 1'b0;
            req_d   = 1'b1;
            pc_d    = jFlag ? target : pc_q;
            addr_d  = jFlag ? target : pc_q;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_plus4;
            pc_d     = pc_plus4;
            if (stall) begin
              state_d = S_HOLD;
              req_d   = 1'b0;
            end else begin
              done_d = 1'b1;
              req_d  = 1'b1;
              addr_d = pc_plus4;
            end
          end
        end else if (jFlag) begin
          // Address must stay stable until ack, so remember to discard it
          pc_d    = target;
          flush_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (jFlag) begin
          instr_d = NOP_WORD;
          pc_d    = target;
          addr_d  = target;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (!stall) begin
          done_d  = 1'b1;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_out_q   <= RESET_PC;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign PC_out      = pc_out_q;
  assign done_out    = done_q;
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven cycle bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        jFlag;
  logic [31:0] PC_in;
  logic [31:0] instr;
  logic [31:0] PC_out;
  logic        done_out;
  logic        misalign;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_fail;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .jFlag       (jFlag),
    .PC_in       (PC_in),
    .instr       (instr),
    .PC_out      (PC_out),
    .done_out    (done_out),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: outputs expected at the negedge of this cycle, then inputs driven for this cycle
  typedef struct {
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_done;
    logic [31:0] e_instr;
    logic [31:0] e_pcout;
    logic [31:0] e_cnt;
    logic        e_mis;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        i_jflag;
    logic [31:0] i_pcin;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t v(logic er, logic [31:0] ea, logic ed, logic [31:0] ei,
                             logic [31:0] ep, logic [31:0] ec, logic em,
                             logic ia, logic [31:0] ird, logic is, logic ij, logic [31:0] ip);
    vec_t r;
    r.e_req = er; r.e_addr = ea; r.e_done = ed; r.e_instr = ei;
    r.e_pcout = ep; r.e_cnt = ec; r.e_mis = em;
    r.i_ack = ia; r.i_rdata = ird; r.i_stall = is; r.i_jflag = ij; r.i_pcin = ip;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [31:0] rd, input logic s,
                       input logic j, input logic [31:0] p);
    imem_ack = a; imem_rdata = rd; stall = s; jFlag = j; PC_in = p;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //             req addr          done instr         pcout         cnt mis | ack rdata        stl jf pc_in
    vecs[0]  = v(0, 32'h0,        0, 32'h0,        32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0);
    vecs[1]  = v(1, 32'h0,        0, 32'h0,        32'h0,        0, 0,  1, 32'h20080005, 0, 0, 32'h0);
    vecs[2]  = v(1, 32'h4,        1, 32'h20080005, 32'h4,        0, 0,  1, 32'h20090003, 0, 0, 32'h0);
    vecs[3]  = v(1, 32'h8,        1, 32'h20090003, 32'h8,        1, 0,  0, 32'h0,        0, 0, 32'h0);
    vecs[4]  = v(1, 32'h8,        0, 32'h20090003, 32'h8,        2, 0,  0, 32'h0,        0, 0, 32'h0);
    vecs[5]  = v(1, 32'h8,        0, 32'h20090003, 32'h8,        2, 0,  0, 32'h0,        0, 0, 32'h0);
    vecs[6]  = v(1, 32'h8,        0, 32'h20090003, 32'h8,        2, 0,  1, 32'h8C0A0000, 1, 0, 32'h0);
    vecs[7]  = v(0, 32'h8,        0, 32'h8C0A0000, 32'hC,        2, 0,  0, 32'h0,        1, 0, 32'h0);
    vecs[8]  = v(0, 32'h8,        0, 32'h8C0A0000, 32'hC,        2, 0,  0, 32'h0,        1, 0, 32'h0);
    vecs[9]  = v(0, 32'h8,        0, 32'h8C0A0000, 32'hC,        2, 0,  0, 32'h0,        0, 0, 32'h0);
    vecs[10] = v(1, 32'hC,        1, 32'h8C0A0000, 32'hC,        2, 0,  0, 32'h0,        0, 1, 32'h40);
    vecs[11] = v(1, 32'hC,        0, 32'h8C0A0000, 32'hC,        3, 0,  1, 32'hDEADBEEF, 0, 0, 32'h0);
    vecs[12] = v(1, 32'h40,       0, 32'h8C0A0000, 32'hC,        3, 0,  1, 32'h00000020, 0, 0, 32'h0);
    vecs[13] = v(1, 32'h44,       1, 32'h00000020, 32'h44,       3, 0,  1, 32'h11111111, 0, 1, 32'h100);
    vecs[14] = v(1, 32'h100,      0, 32'h00000020, 32'h44,       4, 0,  1, 32'h22222222, 0, 0, 32'h0);
    vecs[15] = v(1, 32'h104,      1, 32'h22222222, 32'h104,      4, 0,  0, 32'h0,        0, 1, 32'h42);
    vecs[16] = v(1, 32'h104,      0, 32'h22222222, 32'h104,      5, 1,  1, 32'hBADBAD00, 0, 0, 32'h0);
    vecs[17] = v(1, 32'h40,       0, 32'h22222222, 32'h104,      5, 1,  1, 32'h33333333, 1, 0, 32'h0);
    vecs[18] = v(0, 32'h40,       0, 32'h33333333, 32'h44,       5, 1,  0, 32'h0,        1, 1, 32'h200);
    vecs[19] = v(1, 32'h200,      0, 32'h0,        32'h44,       5, 1,  1, 32'h44444444, 0, 0, 32'h0);
    vecs[20] = v(1, 32'h204,      1, 32'h44444444, 32'h204,      5, 1,  0, 32'h0,        0, 0, 32'h0);
    vecs[21] = v(1, 32'h204,      0, 32'h44444444, 32'h204,      6, 1,  0, 32'h0,        0, 1, 32'hFFFFFFFC);
    vecs[22] = v(1, 32'h204,      0, 32'h44444444, 32'h204,      6, 1,  1, 32'h0BAD0BAD, 0, 0, 32'h0);
    vecs[23] = v(1, 32'hFFFFFFFC, 0, 32'h44444444, 32'h204,      6, 1,  1, 32'h55555555, 0, 0, 32'h0);
    vecs[24] = v(1, 32'h0,        1, 32'h55555555, 32'h0,        6, 1,  0, 32'h0,        0, 0, 32'h0);
    vecs[25] = v(1, 32'h0,        0, 32'h55555555, 32'h0,        7, 1,  0, 32'h0,        0, 0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_done",  {31'd0, done_out}, 32'd0);
    chk("rst_instr", instr,             32'h0);
    chk("rst_pcout", PC_out,            32'h0);
    chk("rst_cnt",   fetch_count,       32'd0);
    chk("rst_mis",   {31'd0, misalign}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("r%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("r%0d_addr", i),  imem_addr,         vecs[i].e_addr);
      chk($sformatf("r%0d_done", i),  {31'd0, done_out}, {31'd0, vecs[i].e_done});
      chk($sformatf("r%0d_instr", i), instr,             vecs[i].e_instr);
      chk($sformatf("r%0d_pcout", i), PC_out,            vecs[i].e_pcout);
      chk($sformatf("r%0d_cnt", i),   fetch_count,       vecs[i].e_cnt);
      chk($sformatf("r%0d_mis", i),   {31'd0, misalign}, {31'd0, vecs[i].e_mis});
      drive(vecs[i].i_ack, vecs[i].i_rdata, vecs[i].i_stall, vecs[i].i_jflag, vecs[i].i_pcin);
    end

    // Asynchronous reset in the middle of an outstanding request
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req",  {31'd0, imem_req}, 32'd0);
    chk("arst_done", {31'd0, done_out}, 32'd0);
    chk("arst_cnt",  fetch_count,       32'd0);
    chk("arst_mis",  {31'd0, misalign}, 32'd0);
    chk("arst_addr", imem_addr,         32'h0);

    // Stale ack during the idle cycle must be ignored
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h66666666, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_ack_req",   {31'd0, imem_req}, 32'd1);
    chk("idle_ack_addr",  imem_addr,         32'h0);
    chk("idle_ack_done",  {31'd0, done_out}, 32'd0);
    chk("idle_ack_instr", instr,             32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_ack_done2", {31'd0, done_out}, 32'd0);
    chk("idle_ack_cnt",   fetch_count,       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
